// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and defaults for the pipeline start/clean/ready stage responders.
package pipeline_ctrl_pkg;

  localparam int unsigned DefaultDataW = 32;
  localparam int unsigned DefaultResW  = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } stage_state_e;

endpackage

// File: rtl/busy_timeout_counter.sv
// Saturating busy-cycle counter with a terminal-count flag at TimeoutCycles-1.
module busy_timeout_counter #(
  parameter int unsigned CntW          = 8,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            enable_i,
  output logic [CntW-1:0] count_o,
  output logic            terminal_o
);

  localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};
  localparam logic [CntW-1:0] CntTerm = CntW'(TimeoutCycles - 1);

  logic [CntW-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != CntMax)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o    = count_q;
  assign terminal_o = (count_q == CntTerm);

endmodule

// File: rtl/pipeline_stage_responder.sv
// Stage responder: latches a task, drives a variable-latency datapath under a timeout
// guard and holds the result until downstream takes it.
module pipeline_stage_responder
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned DataW         = DefaultDataW,
  parameter int unsigned ResW          = DefaultResW,
  parameter int unsigned TimeoutCycles = 255,
  parameter int unsigned CntW          = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             clean_i,
  input  logic             in_valid_i,
  input  logic [DataW-1:0] in_data_i,
  output logic             ready_o,
  output logic             work_go_o,
  output logic [DataW-1:0] work_operand_o,
  input  logic             work_done_i,
  input  logic [ResW-1:0]  work_result_i,
  output logic             work_abort_o,
  output logic             out_valid_o,
  output logic [ResW-1:0]  out_data_o,
  output logic             out_err_o,
  input  logic             out_taken_i,
  output logic [CntW-1:0]  busy_cycles_o
);

  stage_state_e     state_q;
  logic             work_go_q, work_abort_q, out_valid_q, out_err_q;
  logic [DataW-1:0] operand_q;
  logic [ResW-1:0]  out_data_q;
  logic             capture, cnt_enable, cnt_terminal;

  // A new task is accepted from IDLE, or from DONE when the held result leaves the same cycle.
  assign capture = !clean_i && start_i && in_valid_i &&
                   ((state_q == StIdle) || ((state_q == StDone) && out_taken_i));
  assign cnt_enable = (state_q == StBusy) && !clean_i;

  busy_timeout_counter #(
    .CntW          (CntW),
    .TimeoutCycles (TimeoutCycles)
  ) u_counter (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (capture),
    .enable_i   (cnt_enable),
    .count_o    (busy_cycles_o),
    .terminal_o (cnt_terminal)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      work_go_q    <= 1'b0;
      work_abort_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_err_q    <= 1'b0;
      operand_q    <= '0;
      out_data_q   <= '0;
    end else begin
      work_go_q    <= 1'b0;
      work_abort_q <= 1'b0;
      if (clean_i) begin
        state_q      <= StIdle;
        out_valid_q  <= 1'b0;
        out_err_q    <= 1'b0;
        work_abort_q <= (state_q == StBusy);
      end else begin
        unique case (state_q)
          StIdle: begin
            if (capture) begin
              operand_q <= in_data_i;
              work_go_q <= 1'b1;
              state_q   <= StBusy;
            end
          end
          StBusy: begin
            // Completion beats a coincident timeout.
            if (work_done_i) begin
              out_data_q  <= work_result_i;
              out_err_q   <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= StDone;
            end else if (cnt_terminal) begin
              out_data_q   <= '0;
              out_err_q    <= 1'b1;
              out_valid_q  <= 1'b1;
              work_abort_q <= 1'b1;
              state_q      <= StDone;
            end
          end
          StDone: begin
            if (out_taken_i) begin
              out_valid_q <= 1'b0;
              if (capture) begin
                operand_q <= in_data_i;
                work_go_q <= 1'b1;
                state_q   <= StBusy;
              end else begin
                state_q <= StIdle;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign ready_o        = (state_q == StIdle);
  assign work_go_o      = work_go_q;
  assign work_abort_o   = work_abort_q;
  assign work_operand_o = operand_q;
  assign out_valid_o    = out_valid_q;
  assign out_data_o     = out_data_q;
  assign out_err_o      = out_err_q;

endmodule

// File: doc/pipeline_stage_responder.md
Name: pipeline_stage_responder

Overview:
- Per-stage responder at the far end of the assembly-line start/clean/ready protocol.
- The pipeline controller drives start/clean into this block; it returns ready.
- Latches an upstream task, runs it through a variable-latency datapath with a timeout guard, and holds the result until the downstream stage consumes it.
- Instantiated once per fetch/analysis/execute stage.

Parameters:
- DATA_W, 32, width of incoming task payload.
- RES_W, 32, width of datapath result.
- TIMEOUT_CYCLES, 255, max BUSY cycles before forced completion with error; legal range 1..2^CNT_W-1.
- CNT_W, 8, width of the busy-cycle counter.

Ports:
- clk  in  1  stage clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  controller permission to accept a new task this cycle.
- clean  in  1  controller request to flush this stage; synchronous, highest priority.
- in_valid  in  1  upstream task present.
- in_data  in  DATA_W  upstream task payload.
- ready  out  1  stage idle and able to accept; fed back to the controller.
- work_go  out  1  one-cycle pulse launching the datapath.
- work_operand  out  DATA_W  latched payload; stable while BUSY.
- work_done  in  1  datapath completion pulse; valid only while BUSY.
- work_result  in  RES_W  datapath result, sampled with work_done.
- work_abort  out  1  one-cycle pulse when clean or timeout kills an in-flight op.
- out_valid  out  1  result held for downstream.
- out_data  out  RES_W  held result.
- out_err  out  1  held result came from a timeout.
- out_taken  in  1  downstream consumed the result this cycle.
- busy_cycles  out  CNT_W  cycles spent in the current or last BUSY.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE.
  - All outputs 0 except ready=1.
  - Payload, result and counter cleared.
- States: IDLE, BUSY, DONE (2-bit encoding). ready = (state==IDLE), decoded from the registered state; no combinational path from any input.
- IDLE:
  - start && in_valid → capture in_data into work_operand; work_go=1 on the next cycle (registered pulse); busy_cycles←0; → BUSY.
  - start without in_valid → stay IDLE.
  - in_valid without start → ignored; the task is not consumed.
- BUSY:
  - busy_cycles increments each cycle, saturating at 2^CNT_W-1.
  - work_done → out_data←work_result, out_err←0, out_valid←1; → DONE.
  - Otherwise, when busy_cycles reaches TIMEOUT_CYCLES-1 → out_data←0, out_err←1, out_valid←1, work_abort pulse; → DONE.
  - work_done on the same cycle as the timeout wins: the result is taken and there is no abort.
- DONE:
  - out_valid=1 and out_data/out_err are stable until out_taken.
  - out_taken → out_valid←0; → IDLE.
  - out_taken && start && in_valid in the same cycle → back-to-back: release the result, capture the new task and go → BUSY directly. ready stays 0 that cycle.
  - start alone is ignored in DONE.
- clean (any state, sync, overrides everything):
  - → IDLE; out_valid←0, out_err←0.
  - If the state was BUSY, work_abort pulses for 1 cycle.
  - work_go is suppressed.
  - busy_cycles is retained for debug.
  - A work_done arriving in the clean cycle is dropped.
- Latency: capture→work_go 1 cycle. work_done→out_valid 1 cycle. out_taken→ready 1 cycle.
- work_done outside BUSY is ignored.
- Async reset mid-BUSY clears immediately and produces no abort pulse (the datapath shares the reset).

Decomposition:
- Shared package `pipeline_ctrl_pkg`:
  - typedef stage_state_e {IDLE, BUSY, DONE}.
  - Default DATA_W/RES_W constants.
- One natural sub-module: `busy_timeout_counter`. It provides clear, enable, saturating count, and a terminal-count compare against TIMEOUT_CYCLES.

Test Plan:
- Reset release, then start=1, in_valid=1, in_data=0xA5A5_0001 → ready=0 next cycle, work_go pulses once, work_operand=0xA5A5_0001. work_done with result 0x1234 after 3 cycles → out_valid=1, out_data=0x1234, out_err=0, busy_cycles=3.
- Timeout, TIMEOUT_CYCLES=4, work_done never asserted → work_abort at BUSY cycle 4, out_valid=1, out_err=1, out_data=0. out_taken → ready=1 next cycle.
- Back-to-back: in DONE, out_taken=1 with start=1, in_valid=1, in_data=0x55 → state BUSY next cycle, ready stays 0, work_go pulses, no IDLE cycle.
- clean in BUSY at cycle 2 → IDLE next cycle, work_abort one pulse, ready=1. A work_done in the same cycle is dropped, so out_valid stays 0.
- Simultaneous work_done and timeout terminal count → out_err=0, out_data=work_result, no work_abort. Separately, in_valid=1 with start=0 in IDLE for 5 cycles → no capture, ready stays 1.
- Assert rst low mid-BUSY for 1 cycle → all outputs at reset values immediately, ready=1 after release, no work_abort.
